// File: rtl/fsm_pkg.sv
// Shared definitions for the FSM library: overlap-mode encodings and the
// per-edge action selector used by the serial pattern detector.
package fsm_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // What the detector does to its history/fill state on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_SHIFT   = 2'd1,
        ACT_RESTART = 2'd2,
        ACT_LOAD    = 2'd3
    } seq_act_e;

endpackage : fsm_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and the
// count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (clr) begin
            r_cnt <= {W{1'b0}};
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/param_seq_detector.sv
// Mealy serial-pattern detector with runtime-loadable pattern, selectable
// overlap mode, input qualifier, registered match copy and saturating count.
module param_seq_detector
    import fsm_pkg::*;
#(
    parameter int unsigned        SEQ_LEN   = 3,
    parameter logic [SEQ_LEN-1:0] RESET_PAT = 3'b101,
    parameter int unsigned        CNT_W     = 8
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               en,
    input  logic               x,
    input  logic               ovl,
    input  logic               pat_we,
    input  logic [SEQ_LEN-1:0] pat_i,
    input  logic               cnt_clr,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned        FILL_W     = $clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0]  FILL_ARMED = FILL_W'(SEQ_LEN - 1);

    logic [SEQ_LEN-1:0] r_pat;
    logic [SEQ_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_z_q;

    logic [SEQ_LEN-1:0] w_pat_nxt;
    logic [SEQ_LEN-2:0] w_hist_nxt;
    logic [SEQ_LEN-2:0] w_hist_shift;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic               w_armed;
    logic               w_z;
    seq_act_e           w_act;

    // A 2-bit pattern keeps a single history bit, so there is nothing to shift through.
    generate
        if (SEQ_LEN == 2) begin : g_hist_one
            assign w_hist_shift = x;
        end else begin : g_hist_many
            assign w_hist_shift = {r_hist[SEQ_LEN-3:0], x};
        end
    endgenerate

    // Match decode, edge action selection and next-state computation.
    always_comb begin
        w_armed    = (r_fill == FILL_ARMED);
        w_z        = en & ~pat_we & w_armed & ({r_hist, x} == r_pat);
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_act      = ACT_HOLD;

        if (pat_we) begin
            w_act = ACT_LOAD;
        end else if (en) begin
            if (w_z && (ovl == OVL_OFF)) begin
                w_act = ACT_RESTART;
            end else begin
                w_act = ACT_SHIFT;
            end
        end else begin
            w_act = ACT_HOLD;
        end

        case (w_act)
            ACT_LOAD: begin
                w_pat_nxt  = pat_i;
                w_hist_nxt = {(SEQ_LEN-1){1'b0}};
                w_fill_nxt = {FILL_W{1'b0}};
            end
            ACT_RESTART: begin
                w_hist_nxt = w_hist_shift;
                w_fill_nxt = {FILL_W{1'b0}};
            end
            ACT_SHIFT: begin
                w_hist_nxt = w_hist_shift;
                w_fill_nxt = w_armed ? r_fill : (r_fill + FILL_W'(1));
            end
            ACT_HOLD: begin
                w_hist_nxt = r_hist;
            end
            default: begin
                w_hist_nxt = r_hist;
            end
        endcase
    end

    // Pattern, history, fill level and delayed match pulse.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_pat  <= RESET_PAT;
            r_hist <= {(SEQ_LEN-1){1'b0}};
            r_fill <= {FILL_W{1'b0}};
            r_z_q  <= 1'b0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_z_q  <= w_z;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (aresetn),
        .inc   (w_z),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

    assign z   = w_z;
    assign z_q = r_z_q;

endmodule : param_seq_detector

// File: tb/tb_param_seq_detector.sv
// Checks three detector configurations (default, 2-bit counter, 5-bit pattern)
// against a bit-count/window reference model under directed and random stimulus.
module tb_param_seq_detector;
    import fsm_pkg::*;

    logic       clk = 1'b0;
    logic       aresetn, en, x, ovl, pat_we, cnt_clr;
    logic [2:0] pat_i3;
    logic [4:0] pat_i5;
    logic       z0, zq0, z1, zq1, z2, zq2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state per DUT: accepted bits since last restart, window value,
    // current pattern and expected counter.
    int m_len[3];
    int m_rst[3];
    int m_max[3];
    int m_pat[3];
    int m_n[3];
    int m_val[3];
    int m_cnt[3];
    int m_zq[3];
    int m_z[3];

    always #5 clk = ~clk;

    param_seq_detector dut0 (
        .clk(clk), .aresetn(aresetn), .en(en), .x(x), .ovl(ovl),
        .pat_we(pat_we), .pat_i(pat_i3), .cnt_clr(cnt_clr),
        .z(z0), .z_q(zq0), .match_cnt(cnt0)
    );

    param_seq_detector #(.CNT_W(2)) dut1 (
        .clk(clk), .aresetn(aresetn), .en(en), .x(x), .ovl(ovl),
        .pat_we(pat_we), .pat_i(pat_i3), .cnt_clr(cnt_clr),
        .z(z1), .z_q(zq1), .match_cnt(cnt1)
    );

    param_seq_detector #(.SEQ_LEN(5), .RESET_PAT(5'b11011), .CNT_W(8)) dut2 (
        .clk(clk), .aresetn(aresetn), .en(en), .x(x), .ovl(ovl),
        .pat_we(pat_we), .pat_i(pat_i5), .cnt_clr(cnt_clr),
        .z(z2), .z_q(zq2), .match_cnt(cnt2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_match(input int k);
        int win;
        win = (m_val[k] * 2 + int'(x)) % (1 << m_len[k]);
        return (en && !pat_we && (m_n[k] >= m_len[k] - 1) && (win == m_pat[k])) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pat[k] = m_rst[k];
            m_n[k]   = 0;
            m_val[k] = 0;
            m_cnt[k] = 0;
            m_zq[k]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            m_zq[k] = m_z[k];
            if (cnt_clr) m_cnt[k] = 0;
            else if (m_z[k] == 1 && m_cnt[k] < m_max[k]) m_cnt[k]++;
            if (pat_we) begin
                m_pat[k] = (k == 2) ? int'(pat_i5) : int'(pat_i3);
                m_n[k]   = 0;
                m_val[k] = 0;
            end else if (en) begin
                m_val[k] = (m_val[k] * 2 + int'(x)) % (1 << m_len[k]);
                m_n[k]++;
                if (m_z[k] == 1 && ovl == OVL_OFF) m_n[k] = 0;
            end
        end
    endtask

    task automatic check_z();
        for (int k = 0; k < 3; k++) m_z[k] = exp_match(k);
        check("z0", int'(z0), m_z[0]);
        check("z1", int'(z1), m_z[1]);
        check("z2", int'(z2), m_z[2]);
    endtask

    task automatic check_regs();
        check("zq0", int'(zq0), m_zq[0]);
        check("zq1", int'(zq1), m_zq[1]);
        check("zq2", int'(zq2), m_zq[2]);
        check("cnt0", int'(cnt0), m_cnt[0]);
        check("cnt1", int'(cnt1), m_cnt[1]);
        check("cnt2", int'(cnt2), m_cnt[2]);
    endtask

    // Entered with clk low; leaves at the following falling edge.
    task automatic step(input logic e, input logic xv);
        en = e;
        x  = xv;
        #1;
        check_z();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
        pat_we  = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        model_reset();
        check_z();
        check_regs();
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
    endtask

    initial begin
        m_len = '{3, 3, 5};
        m_rst = '{5, 5, 27};
        m_max = '{255, 3, 255};
        aresetn = 1'b0; en = 1'b0; x = 1'b0; ovl = OVL_ON;
        pat_we = 1'b0; cnt_clr = 1'b0; pat_i3 = 3'b000; pat_i5 = 5'b00000;
        model_reset();
        @(negedge clk);
        do_reset();

        // Overlapping 10101: two matches sharing a bit.
        ovl = OVL_ON;
        feed(16'b10101, 5);
        step(1'b0, 1'b0);
        check("t1_cnt", int'(cnt0), 2);

        // Non-overlapping: third and seventh bits only.
        do_reset();
        ovl = OVL_OFF;
        feed(16'b1010101, 7);
        check("t2_cnt", int'(cnt0), 2);

        // Enable gaps with ignored bits do not break a partial match.
        do_reset();
        ovl = OVL_ON;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("t3_cnt", int'(cnt0), 1);

        // Pattern reload mid-stream discards history and the write-cycle bit.
        do_reset();
        feed(16'b10, 2);
        pat_i3 = 3'b110;
        pat_i5 = 5'b00110;
        pat_we = 1'b1;
        step(1'b1, 1'b1);
        feed(16'b110, 3);
        check("t4_cnt", int'(cnt0), 1);

        // Two-bit counter saturates; clear wins over a same-cycle match.
        do_reset();
        ovl = OVL_ON;
        feed(16'b101010101, 9);
        check("t5_sat", int'(cnt1), 3);
        step(1'b1, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        check("t5_clr", int'(cnt1), 0);

        // Asynchronous reset with a completing bit pending.
        do_reset();
        feed(16'b10, 2);
        en = 1'b1;
        x  = 1'b1;
        #1;
        check("t6_pre", int'(z0), 1);
        do_reset();
        feed(16'b101, 3);
        check("t6_cnt", int'(cnt0), 1);

        // Five-bit reset pattern 11011 with overlap.
        do_reset();
        ovl = OVL_ON;
        feed(16'b11011011, 8);
        check("t7_cnt", int'(cnt2), 2);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) ovl = logic'($urandom_range(0, 1));
            pat_we  = ($urandom_range(0, 49) == 0);
            pat_i3  = 3'($urandom);
            pat_i5  = 5'($urandom);
            cnt_clr = ($urandom_range(0, 59) == 0);
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_seq_detector
